// File: rtl/tri_bus_arbiter.sv
// Round-robin owner selection for a shared tri-state net: one-hot registered drive enables,
// a bounded hold time per owner and forced all-off turnaround cycles between owners.
module tri_bus_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_HOLD  = 8,
    parameter int TA_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] owner_id,
    output logic                       bus_busy,
    output logic                       preempt
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int HCW = $clog2(MAX_HOLD + 1);
    localparam int TCW = $clog2(TA_CYCLES + 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
    localparam logic [TCW-1:0] TA_LAST   = TCW'(TA_CYCLES - 1);
    localparam logic [IDW-1:0] ID_LAST   = IDW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURNAROUND
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [NUM_REQ-1:0] gnt_next;
    logic [IDW-1:0]     owner_next;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     rr_ptr_next;
    logic [HCW-1:0]     hold_cnt;
    logic [HCW-1:0]     hold_next;
    logic [TCW-1:0]     ta_cnt;
    logic [TCW-1:0]     ta_next;
    logic               preempt_next;
    logic               win_found;
    logic [IDW-1:0]     win_id;
    logic               owner_req;
    logic               hold_done;

    assign owner_req = req[owner_id];
    assign hold_done = (hold_cnt == HOLD_LAST);

    // Search upward from rr_ptr, wrapping at NUM_REQ, for the first pending request.
    always_comb begin
        int              idx;
        logic [IDW-1:0]  cand;
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = IDW'(idx);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            owner_id <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            ta_cnt   <= '0;
            preempt  <= 1'b0;
        end else begin
            state    <= state_next;
            gnt      <= gnt_next;
            owner_id <= owner_next;
            rr_ptr   <= rr_ptr_next;
            hold_cnt <= hold_next;
            ta_cnt   <= ta_next;
            preempt  <= preempt_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (win_found) state_next = GRANT;
            GRANT:      if (!owner_req || hold_done) state_next = TURNAROUND;
            TURNAROUND: if (ta_cnt == TA_LAST) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // A release that coincides with the timeout counts as voluntary, so preempt needs req still high.
    always_comb begin
        gnt_next     = gnt;
        owner_next   = owner_id;
        rr_ptr_next  = rr_ptr;
        hold_next    = hold_cnt;
        ta_next      = ta_cnt;
        preempt_next = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    gnt_next    = NUM_REQ'(1) << win_id;
                    owner_next  = win_id;
                    rr_ptr_next = (win_id == ID_LAST) ? '0 : win_id + 1'b1;
                    hold_next   = '0;
                end
            end
            GRANT: begin
                if (state_next == TURNAROUND) begin
                    gnt_next     = '0;
                    ta_next      = '0;
                    preempt_next = hold_done && owner_req;
                end else begin
                    hold_next = hold_cnt + 1'b1;
                end
            end
            TURNAROUND: begin
                if (ta_cnt != TA_LAST) begin
                    ta_next = ta_cnt + 1'b1;
                end
            end
            default: gnt_next = '0;
        endcase
    end

    assign bus_busy = |gnt;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Scoreboard bench for tri_bus_arbiter: two instances (hold 8/turnaround 1 and hold 3/turnaround 2)
// share one request stream; ownership episodes are predicted from the request history and compared.
module tb_tri_bus_arbiter;

    localparam int NREQ = 4;

    typedef struct {
        int start;
        int owner;
        int len;
        bit pre;
    } txn_t;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [NREQ-1:0] req   = '0;
    logic [NREQ-1:0] gv   [2];
    logic [1:0]      oid  [2];
    logic            busy [2];
    logic            pre  [2];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    logic [NREQ-1:0] stim [$];
    txn_t            exp0 [$];
    txn_t            exp1 [$];
    txn_t            obs0 [$];

    bit              in_ep     [2];
    bit              have_last [2];
    int              ep_start  [2];
    int              last_end  [2];
    logic [NREQ-1:0] prev_g    [2];
    logic [NREQ-1:0] mg;
    txn_t            mx;
    bit              mend;

    tri_bus_arbiter #(.NUM_REQ(NREQ), .MAX_HOLD(8), .TA_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gv[0]), .owner_id(oid[0]),
        .bus_busy(busy[0]), .preempt(pre[0])
    );

    tri_bus_arbiter #(.NUM_REQ(NREQ), .MAX_HOLD(3), .TA_CYCLES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gv[1]), .owner_id(oid[1]),
        .bus_busy(busy[1]), .preempt(pre[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int maxHold(input int i);
        return (i == 0) ? 8 : 3;
    endfunction

    function automatic int taCycles(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic logic [NREQ-1:0] reqAt(input int t);
        if (t < stim.size()) return stim[t];
        return '0;
    endfunction

    function automatic int gntIndex(input logic [NREQ-1:0] g);
        int r;
        r = -1;
        for (int k = 0; k < NREQ; k++) if (g[k] && r < 0) r = k;
        return r;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Walks the request history as the arbiter should see it: one arbitration per free edge,
    // an episode ending at the first edge the owner's request is low or at the hold cap.
    task automatic buildExpected(input int inst, input int base);
        int              t, ptr, w, j, c, mh, ta;
        bit              more;
        logic [NREQ-1:0] r;
        txn_t            x;
        t   = 0;
        ptr = 0;
        mh  = maxHold(inst);
        ta  = taCycles(inst);
        while (t < stim.size()) begin
            r = reqAt(t);
            if (r == '0) begin
                t++;
            end else begin
                w = -1;
                for (int k = 0; k < NREQ; k++) begin
                    c = (ptr + k) % NREQ;
                    if (w < 0 && r[c[1:0]]) w = c;
                end
                ptr  = (w + 1) % NREQ;
                j    = 1;
                more = 1'b1;
                while (more && j < mh) begin
                    r = reqAt(t + j);
                    if (r[w[1:0]]) j++;
                    else more = 1'b0;
                end
                r       = reqAt(t + j);
                x.start = base + t;
                x.owner = w;
                x.len   = j;
                x.pre   = (j == mh) && r[w[1:0]];
                if (inst == 0) exp0.push_back(x);
                else exp1.push_back(x);
                t = t + j + ta + 1;
            end
        end
    endtask

    task automatic popCompare(input int i, input txn_t a);
        txn_t e;
        int   sz;
        sz = (i == 0) ? exp0.size() : exp1.size();
        if (sz == 0) begin
            checkOutput($sformatf("dut%0d_unexpected_grant_owner", i), a.owner, -1);
            return;
        end
        if (i == 0) e = exp0.pop_front();
        else e = exp1.pop_front();
        checkOutput($sformatf("dut%0d_start", i), a.start, e.start);
        checkOutput($sformatf("dut%0d_owner", i), a.owner, e.owner);
        checkOutput($sformatf("dut%0d_length", i), a.len, e.len);
        checkOutput($sformatf("dut%0d_preempt", i), int'(a.pre), int'(e.pre));
    endtask

    // Monitor: reconstructs ownership episodes from gnt and checks per-cycle invariants.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n || !mon_en) begin
                in_ep[i]     = 1'b0;
                have_last[i] = 1'b0;
            end else begin
                mg   = gv[i];
                mend = in_ep[i] && (mg == '0);
                checkOutput("onehot0_gnt", int'($onehot0(mg)), 1);
                checkOutput("bus_busy", int'(busy[i]), int'(|mg));
                if (mg != '0) checkOutput("owner_id", int'(oid[i]), gntIndex(mg));
                if (!mend) checkOutput("preempt_quiet", int'(pre[i]), 0);
                if (in_ep[i]) begin
                    if (mg != '0) begin
                        checkOutput("gnt_stable", int'(mg), int'(prev_g[i]));
                    end else begin
                        mx.start = ep_start[i];
                        mx.owner = gntIndex(prev_g[i]);
                        mx.len   = cyc - ep_start[i];
                        mx.pre   = pre[i];
                        checkOutput("hold_limit", int'(mx.len <= maxHold(i)), 1);
                        if (i == 0) obs0.push_back(mx);
                        popCompare(i, mx);
                        in_ep[i]     = 1'b0;
                        have_last[i] = 1'b1;
                        last_end[i]  = cyc;
                    end
                end else if (mg != '0) begin
                    if (have_last[i])
                        checkOutput("turnaround_gap", int'((cyc - last_end[i]) >= taCycles(i) + 1), 1);
                    in_ep[i]    = 1'b1;
                    ep_start[i] = cyc;
                end
            end
            prev_g[i] = gv[i];
        end
    end

    task automatic applyStimulus(input int tail);
        int base;
        @(negedge clk);
        #2 rst_n = 1'b0;
        req = '0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        exp0.delete();
        exp1.delete();
        obs0.delete();
        base = cyc + 1;
        buildExpected(0, base);
        buildExpected(1, base);
        foreach (stim[t]) begin
            req = stim[t];
            @(negedge clk);
            #2;
        end
        req = '0;
        repeat (tail) @(negedge clk);
        #2;
        checkOutput("dut0_drained", exp0.size(), 0);
        checkOutput("dut1_drained", exp1.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int              exp_own [5];
        logic [NREQ-1:0] r;
        exp_own = '{0, 1, 2, 3, 0};

        // Reset values, then reset asserted between edges while both instances hold a grant.
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checkOutput("reset_gnt", int'(gv[i]), 0);
            checkOutput("reset_busy", int'(busy[i]), 0);
            checkOutput("reset_owner", int'(oid[i]), 0);
            checkOutput("reset_preempt", int'(pre[i]), 0);
        end
        req = 4'b0001;
        repeat (2) @(negedge clk);
        checkOutput("pre_reset_gnt_a", int'(gv[0]), 1);
        checkOutput("pre_reset_gnt_b", int'(gv[1]), 1);
        #3 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checkOutput("async_reset_gnt", int'(gv[i]), 0);
            checkOutput("async_reset_busy", int'(busy[i]), 0);
        end
        req = '0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            checkOutput("post_reset_gnt", int'(gv[i]), 0);
            checkOutput("post_reset_busy", int'(busy[i]), 0);
            checkOutput("post_reset_owner", int'(oid[i]), 0);
        end
        mon_en = 1'b1;

        // Single requester held three cycles.
        stim.delete();
        repeat (3) stim.push_back(4'b0010);
        applyStimulus(20);
        checkOutput("single_count", obs0.size(), 1);
        if (obs0.size() >= 1) begin
            checkOutput("single_owner", obs0[0].owner, 1);
            checkOutput("single_len", obs0[0].len, 3);
            checkOutput("single_pre", int'(obs0[0].pre), 0);
        end

        // All four requesting: strict rotation with timeouts.
        stim.delete();
        repeat (45) stim.push_back(4'b1111);
        applyStimulus(20);
        checkOutput("rr_count", obs0.size(), 5);
        if (obs0.size() >= 5) begin
            for (int k = 0; k < 5; k++) checkOutput($sformatf("rr_owner%0d", k), obs0[k].owner, exp_own[k]);
            for (int k = 0; k < 4; k++) begin
                checkOutput($sformatf("rr_len%0d", k), obs0[k].len, 8);
                checkOutput($sformatf("rr_pre%0d", k), int'(obs0[k].pre), 1);
            end
        end

        // Two requesters: the preempted one waits for the other.
        stim.delete();
        repeat (30) stim.push_back(4'b0011);
        applyStimulus(20);
        if (obs0.size() >= 2) begin
            checkOutput("fair_first_owner", obs0[0].owner, 0);
            checkOutput("fair_first_pre", int'(obs0[0].pre), 1);
            checkOutput("fair_second_owner", obs0[1].owner, 1);
        end else begin
            checkOutput("fair_count", obs0.size(), 2);
        end

        // Release on the same edge as the timeout.
        stim.delete();
        repeat (8) stim.push_back(4'b0100);
        applyStimulus(20);
        checkOutput("both_count", obs0.size(), 1);
        if (obs0.size() >= 1) begin
            checkOutput("both_len", obs0[0].len, 8);
            checkOutput("both_pre", int'(obs0[0].pre), 0);
        end

        // Random level requests that toggle occasionally.
        stim.delete();
        r = '0;
        for (int t = 0; t < 10000; t++) begin
            for (int b = 0; b < NREQ; b++) if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
            stim.push_back(r);
        end
        applyStimulus(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
